rx_pkt_bank_scheduler: RTL and testbench

Controls a pool of packet-buffer banks between the 64-bit receive stream and the downstream packet consumer. For each packet it allocates a free bank, generates byte-enabled write strobes and byte addresses, and queues completed packets in arrival order. Completed packets are handed to the consumer until it releases the bank. Packets that arrive when no bank is free are dropped and counted. The block sits between the network receive interface and the bank RAMs/parser. It carries no payload data; the data path goes straight to the bank RAMs, aligned with the write strobes.

---
 rtl/rx_pkt_pkg.sv | 15 +
 rtl/rx_pkt_desc_fifo.sv | 47 ++++
 rtl/rx_pkt_bank_scheduler.sv | 117 +++++++++++
 tb/tb_rx_pkt_bank_scheduler.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/rx_pkt_pkg.sv
// rx_pkt_pkg: shared types for the receive packet bank scheduler.
//   state_t    - receive state machine encoding
//   pkt_desc_t - completed-packet descriptor {bank, len, err}, sized for the
//                largest supported bank count and byte count
package rx_pkt_pkg;
    localparam int BEAT_BYTES  = 8;
    localparam int DESC_BANK_W = 3;
    localparam int DESC_LEN_W  = 16;
    typedef enum logic [1:0] {IDLE, RECV, DISCARD} state_t;
    typedef struct packed {
        logic [DESC_BANK_W-1:0] bank;
        logic [DESC_LEN_W-1:0]  len;
        logic                   err;
    } pkt_desc_t;
endpackage

// File: rtl/rx_pkt_desc_fifo.sv
// rx_pkt_desc_fifo: synchronous FIFO of packet descriptors.
//   clk, rst        - clock, synchronous active-high reset
//   push_i, din_i   - enqueue a descriptor
//   pop_i           - dequeue the head (ignored when empty)
//   head_o          - current head, all-zero when empty
//   empty_o, full_o - occupancy flags
module rx_pkt_desc_fifo
    import rx_pkt_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push_i,
    input  logic      pop_i,
    input  pkt_desc_t din_i,
    output pkt_desc_t head_o,
    output logic      empty_o,
    output logic      full_o
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    pkt_desc_t      mem_q [DEPTH];
    logic [PW-1:0]  rd_q, wr_q;
    logic [PW:0]    cnt_q;
    logic           do_push, do_pop;
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction
    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == (PW+1)'(DEPTH);
    assign do_pop  = pop_i && !empty_o;
    // a push into a full FIFO is accepted only when the head leaves the same cycle
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = empty_o ? '0 : mem_q[rd_q];
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) mem_q[wr_q] <= din_i;
            wr_q  <= do_push ? nxt(wr_q) : wr_q;
            rd_q  <= do_pop ? nxt(rd_q) : rd_q;
            cnt_q <= cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/rx_pkt_bank_scheduler.sv
// rx_pkt_bank_scheduler: allocates packet-buffer banks to the 64-bit receive
// stream, generates byte-enabled write strobes and queues completed packets.
//   clk_net, rst                  - clock, synchronous active-high reset
//   valid, sop, eop, length       - receive beat qualifiers
//   wr_en, wr_bank, wr_addr,
//   wr_byte_en                    - combinational bank RAM write strobe
//   pkt_avail, pkt_bank, pkt_len,
//   pkt_err, pkt_release          - completed-packet queue head / pop
//   drop_cnt                      - saturating count of dropped packets
//   busy                          - receive FSM not idle
module rx_pkt_bank_scheduler
    import rx_pkt_pkg::*;
#(
    parameter int NUM_BANKS      = 2,
    parameter int MAX_PACKET_LEN = 1500,
    parameter int BANK_W         = $clog2(NUM_BANKS),
    parameter int LEN_W          = 11
) (
    input  logic              clk_net,
    input  logic              rst,
    input  logic              valid,
    input  logic              sop,
    input  logic              eop,
    input  logic [2:0]        length,
    output logic              wr_en,
    output logic [BANK_W-1:0] wr_bank,
    output logic [LEN_W-1:0]  wr_addr,
    output logic [7:0]        wr_byte_en,
    output logic              pkt_avail,
    output logic [BANK_W-1:0] pkt_bank,
    output logic [LEN_W-1:0]  pkt_len,
    output logic              pkt_err,
    input  logic              pkt_release,
    output logic [15:0]       drop_cnt,
    output logic              busy
);
    localparam int CW = LEN_W + 1;
    localparam logic [CW-1:0] MAX = CW'(MAX_PACKET_LEN);
    // cursor stops at the first beat boundary past capacity so addresses stay 8-aligned
    localparam logic [CW-1:0] CAP = CW'((MAX_PACKET_LEN + BEAT_BYTES - 1) / BEAT_BYTES * BEAT_BYTES);
    state_t               state_q;
    logic [BANK_W-1:0]    bank_q, low_free;
    logic [CW-1:0]        cursor_q, cur, bb, sum;
    logic [NUM_BANKS-1:0] inq_q, inq_d, free;
    logic [15:0]          drop_q;
    logic                 err_q, err_cur, ovf, any_free, start, beat, push, pop, empty, full, drop;
    pkt_desc_t            in_desc, head;
    always_comb begin
        free = ~inq_q;
        if (state_q == RECV) free[bank_q] = 1'b0;
        any_free = |free;
        low_free = '0;
        for (int i = NUM_BANKS - 1; i >= 0; i--) low_free = free[i] ? BANK_W'(i) : low_free;
    end
    assign start   = !rst && state_q == IDLE && valid && sop && any_free;
    assign beat    = start || (!rst && state_q == RECV && valid);
    // a sop while receiving restarts the packet at address 0 in the same bank
    assign cur     = (state_q == RECV && !sop) ? cursor_q : '0;
    assign err_cur = state_q == RECV && !sop && err_q;
    assign bb      = eop ? CW'(length) + CW'(1) : CW'(BEAT_BYTES);
    assign sum     = cur + bb;
    assign ovf     = sum > MAX;
    assign wr_bank = state_q == RECV ? bank_q : low_free;
    assign wr_addr = cur[LEN_W-1:0];
    always_comb begin
        for (int i = 0; i < BEAT_BYTES; i++) wr_byte_en[i] = beat && CW'(i) < bb && cur + CW'(i) < MAX;
    end
    assign wr_en   = |wr_byte_en;
    assign push    = beat && eop;
    assign pop     = pkt_release && !empty;
    assign drop    = valid && sop && (state_q == RECV || (state_q == IDLE && !any_free));
    assign in_desc = '{bank: DESC_BANK_W'(wr_bank), len: DESC_LEN_W'(ovf ? MAX : sum), err: err_cur || ovf};
    always_comb begin
        inq_d = inq_q;
        if (pop) inq_d[pkt_bank] = 1'b0;
        if (push) inq_d[wr_bank] = 1'b1;
    end
    rx_pkt_desc_fifo #(.DEPTH(NUM_BANKS)) u_fifo (
        .clk     (clk_net),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (in_desc),
        .head_o  (head),
        .empty_o (empty),
        .full_o  (full)
    );
    always_ff @(posedge clk_net) begin
        if (rst) begin
            state_q  <= IDLE;
            bank_q   <= '0;
            cursor_q <= '0;
            err_q    <= 1'b0;
            inq_q    <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= !valid ? state_q :
                        (state_q == IDLE && sop && !eop) ? (any_free ? RECV : DISCARD) :
                        (state_q != IDLE && eop) ? IDLE : state_q;
            bank_q   <= beat ? wr_bank : bank_q;
            cursor_q <= beat ? (sum > CAP ? CAP : sum) : cursor_q;
            err_q    <= beat ? err_cur || ovf : err_q;
            inq_q    <= inq_d;
            drop_q   <= (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
        end
    end
    // the queue holds at most one entry per bank, so it never overflows
    always_ff @(posedge clk_net) begin
        if (!rst) assert (32'(head.bank) < NUM_BANKS && 32'(head.len) <= MAX_PACKET_LEN && !(push && full && !pop));
    end
    assign pkt_avail = !empty;
    assign pkt_bank  = head.bank[BANK_W-1:0];
    assign pkt_len   = head.len[LEN_W-1:0];
    assign pkt_err   = head.err;
    assign drop_cnt  = drop_q;
    assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_rx_pkt_bank_scheduler.sv
// tb_rx_pkt_bank_scheduler: directed and randomized checks against a packet-level model.
module tb_rx_pkt_bank_scheduler;
    localparam int NB   = 2;
    localparam int MAXL = 1500;
    logic       clk_net = 0, rst = 1, valid = 0, sop = 0, eop = 0, pkt_release = 0;
    logic [2:0] length = 0;
    logic       wr_en, pkt_avail, pkt_err, busy;
    logic [0:0] wr_bank, pkt_bank;
    logic [10:0] wr_addr, pkt_len;
    logic [7:0] wr_byte_en;
    logic [15:0] drop_cnt;
    int checks = 0, failures = 0;

    rx_pkt_bank_scheduler dut (
        .clk_net(clk_net), .rst(rst), .valid(valid), .sop(sop), .eop(eop), .length(length),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_byte_en(wr_byte_en),
        .pkt_avail(pkt_avail), .pkt_bank(pkt_bank), .pkt_len(pkt_len), .pkt_err(pkt_err),
        .pkt_release(pkt_release), .drop_cnt(drop_cnt), .busy(busy)
    );

    always #5 clk_net = ~clk_net;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
        end
    endtask

    // packet-level reference: mode 0 idle, 1 receiving, 2 discarding
    int qb[$], ql[$], qe[$];
    int m_mode = 0, m_bank = 0, m_bytes = 0, m_drops = 0;
    int lowest, off, n, tot, bank_e;
    logic [7:0] en;
    bit wr, ok = 0;

    function automatic bit queued(input int b);
        foreach (qb[k]) if (qb[k] == b) return 1;
        return 0;
    endfunction

    task automatic enq(input int b, input int t);
        qb.push_back(b);
        ql.push_back(t > MAXL ? MAXL : t);
        qe.push_back(t > MAXL ? 1 : 0);
    endtask

    always @(negedge clk_net) begin
        if (ok) begin
            chk("busy", busy, m_mode != 0);
            chk("pkt_avail", pkt_avail, qb.size() != 0);
            chk("pkt_bank", pkt_bank, qb.size() != 0 ? qb[0] : 0);
            chk("pkt_len", pkt_len, qb.size() != 0 ? ql[0] : 0);
            chk("pkt_err", pkt_err, qb.size() != 0 ? qe[0] : 0);
            chk("drop_cnt", drop_cnt, m_drops > 65535 ? 65535 : m_drops);
        end
        lowest = -1;
        for (int b = NB - 1; b >= 0; b--) if (!queued(b) && !(m_mode == 1 && m_bank == b)) lowest = b;
        wr = 0; off = 0; bank_e = 0;
        if (!rst && valid) begin
            if (m_mode == 0 && sop && lowest >= 0) begin wr = 1; bank_e = lowest; end
            else if (m_mode == 1) begin wr = 1; bank_e = m_bank; off = sop ? 0 : m_bytes; end
        end
        n = eop ? int'(length) + 1 : 8;
        en = 0;
        for (int i = 0; i < 8; i++) if (wr && i < n && off + i < MAXL) en[i] = 1;
        if (ok) begin
            chk("wr_en", wr_en, en != 0);
            chk("wr_byte_en", wr_byte_en, en);
            if (en != 0) begin
                chk("wr_addr", wr_addr, off);
                chk("wr_bank", wr_bank, bank_e);
            end
        end
        if (rst) begin
            qb.delete(); ql.delete(); qe.delete();
            m_mode = 0; m_bank = 0; m_bytes = 0; m_drops = 0; ok = 1;
        end else begin
            if (pkt_release && qb.size() != 0) begin
                void'(qb.pop_front()); void'(ql.pop_front()); void'(qe.pop_front());
            end
            if (valid) begin
                if (m_mode == 0 && sop) begin
                    if (lowest < 0) begin m_drops++; m_mode = eop ? 0 : 2; end
                    else if (eop) enq(lowest, n);
                    else begin m_mode = 1; m_bank = lowest; m_bytes = n; end
                end else if (m_mode == 1) begin
                    if (sop) m_drops++;
                    tot = off + n;
                    if (eop) begin enq(m_bank, tot); m_mode = 0; end
                    else m_bytes = tot;
                end else if (m_mode == 2 && eop) m_mode = 0;
            end
        end
    end

    task automatic step(input bit v, input bit s, input bit e, input int l, input bit r, input bit rs);
        @(posedge clk_net);
        #1;
        valid = v; sop = s; eop = e; length = 3'(l); pkt_release = r; rst = rs;
        @(negedge clk_net);
    endtask
    task automatic idle();     step(0, 0, 0, 0, 0, 0); endtask
    task automatic rel();      step(0, 0, 0, 0, 1, 0); endtask
    task automatic do_reset(); step(0, 0, 0, 0, 0, 1); endtask

    initial begin
        do_reset(); do_reset();
        chk("rst_avail", pkt_avail, 0); chk("rst_busy", busy, 0); chk("rst_drop", drop_cnt, 0);
        chk("rst_wr_en", wr_en, 0); chk("rst_len", pkt_len, 0); chk("rst_bank", pkt_bank, 0);
        // 20-byte packet
        step(1, 1, 0, 0, 0, 0); chk("p20_addr0", wr_addr, 0); chk("p20_be0", wr_byte_en, 8'hFF);
        step(1, 0, 0, 0, 0, 0); chk("p20_addr1", wr_addr, 8);
        step(1, 0, 1, 3, 0, 0); chk("p20_addr2", wr_addr, 16); chk("p20_be2", wr_byte_en, 8'h0F);
        idle(); chk("p20_avail", pkt_avail, 1); chk("p20_len", pkt_len, 20);
        chk("p20_bank", pkt_bank, 0); chk("p20_err", pkt_err, 0);
        rel(); idle(); chk("p20_freed", pkt_avail, 0);
        // three single-beat packets, two banks
        step(1, 1, 1, 7, 0, 0); chk("s3_bank0", wr_bank, 0);
        step(1, 1, 1, 7, 0, 0); chk("s3_bank1", wr_bank, 1);
        step(1, 1, 1, 7, 0, 0); chk("s3_drop_wr", wr_en, 0);
        idle(); chk("s3_drop", drop_cnt, 1); chk("s3_head0", pkt_bank, 0);
        rel(); idle(); chk("s3_head1", pkt_bank, 1);
        rel(); idle(); chk("s3_empty", pkt_avail, 0);
        // 1504-byte oversize packet
        do_reset();
        step(1, 1, 0, 0, 0, 0);
        for (int k = 1; k < 187; k++) step(1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 7, 0, 0); chk("big_addr", wr_addr, 1496); chk("big_be", wr_byte_en, 8'h0F);
        idle(); chk("big_len", pkt_len, 1500); chk("big_err", pkt_err, 1);
        rel(); idle();
        // sop mid-packet, then 9-byte packet
        do_reset();
        step(1, 1, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0); chk("ab_addr", wr_addr, 0); chk("ab_bank", wr_bank, 0);
        step(1, 0, 1, 0, 0, 0); chk("ab_addr1", wr_addr, 8); chk("ab_be", wr_byte_en, 8'h01);
        idle(); chk("ab_drop", drop_cnt, 1); chk("ab_len", pkt_len, 9); chk("ab_bank_q", pkt_bank, 0);
        rel(); idle();
        // release concurrent with completion
        do_reset();
        step(1, 1, 1, 7, 0, 0);
        step(1, 1, 0, 0, 0, 0); chk("cc_bank1", wr_bank, 1);
        step(1, 0, 1, 7, 1, 0);
        step(1, 1, 1, 7, 0, 0); chk("cc_head", pkt_bank, 1); chk("cc_alloc", wr_bank, 0); chk("cc_wr", wr_en, 1);
        idle(); chk("cc_head2", pkt_bank, 1);
        rel(); rel(); idle(); chk("cc_empty", pkt_avail, 0);
        // reset during RECV
        step(1, 1, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0);
        do_reset(); idle();
        chk("rr_busy", busy, 0); chk("rr_avail", pkt_avail, 0); chk("rr_drop", drop_cnt, 0);
        step(1, 1, 1, 7, 0, 0); chk("rr_bank", wr_bank, 0);
        rel(); idle();
        // randomized traffic
        repeat (80) begin
            int len, nb;
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(1490, 1520) : $urandom_range(1, 40);
            nb = (len + 7) / 8;
            for (int k = 0; k < nb; k++) begin
                bit last;
                last = k == nb - 1;
                step($urandom_range(0, 7) != 0, k == 0 || $urandom_range(0, 40) == 0, last,
                     last ? len - 1 - 8 * (nb - 1) : int'($urandom_range(0, 7)),
                     $urandom_range(0, 3) == 0, $urandom_range(0, 600) == 0);
            end
            repeat ($urandom_range(0, 3))
                step($urandom_range(0, 1), 0, $urandom_range(0, 1), $urandom_range(0, 7),
                     $urandom_range(0, 2) == 0, 0);
        end
        idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
